// File: rtl/rx_byte_pacer_pkg.sv
// Shared sizing defaults, helper sizing function and pacer FSM state type for rx_byte_pacer.
// The short-gap SIM variants keep bench runs brief without touching the production defaults.
package rx_byte_pacer_pkg;

    localparam int RX_PACER_DEPTH             = 8;
    localparam int RX_PACER_MIN_GAP_TICKS     = 4;
    localparam int RX_PACER_DATA_WIDTH        = 8;

    localparam int RX_PACER_SIM_DEPTH         = 4;
    localparam int RX_PACER_SIM_MIN_GAP_TICKS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } pacer_state_t;

    // Occupancy must reach DEPTH itself, hence one bit more than the pointer width.
    function automatic int rx_pacer_count_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// DEPTH x DATA_WIDTH storage with free-running wrapping pointers and a registered read port.
// Fill tracking lives in the owner; this block never refuses a write or a read.
module rx_byte_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk_in) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // A write and read to the same slot on one edge returns the old head, as a full FIFO needs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_rd_en) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_byte_pacer.sv
// Elastic byte buffer that re-issues received bytes as spaced single-cycle pulses, held off by consumer_busy.
// Optional statistics outputs are enabled with `define RX_BYTE_PACER_STATS_EN.
module rx_byte_pacer
    import rx_byte_pacer_pkg::*;
#(
    parameter int DEPTH         = RX_PACER_DEPTH,
    parameter int MIN_GAP_TICKS = RX_PACER_MIN_GAP_TICKS,
    parameter int DATA_WIDTH    = RX_PACER_DATA_WIDTH
) (
    input  logic                                   clk_in,
    input  logic                                   reset,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic                                   in_pulse,
    input  logic                                   consumer_busy,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic                                   out_pulse,
    output logic [rx_pacer_count_bits(DEPTH)-1:0]  occupancy,
    output logic                                   overflow,
    input  logic                                   clear_overflow
`ifdef RX_BYTE_PACER_STATS_EN
    ,
    output logic [15:0]                            bytes_in_count,
    output logic [15:0]                            bytes_dropped_count,
    output logic [rx_pacer_count_bits(DEPTH)-1:0]  peak_occupancy
`endif
);

    localparam int CNT_W = rx_pacer_count_bits(DEPTH);
    localparam int GAP_W = $clog2(MIN_GAP_TICKS + 1);

    pacer_state_t     r_state;
    pacer_state_t     w_state_next;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_next;
    logic [CNT_W-1:0] r_occupancy;
    logic [CNT_W-1:0] w_occ_next;
    logic             r_out_pulse;
    logic             r_overflow;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_full = (r_occupancy == CNT_W'(DEPTH));
    assign w_pop  = (r_state == IDLE) && (r_occupancy != '0) && !consumer_busy;
    // A same-cycle pop frees the head slot, so a push into a full FIFO still fits.
    assign w_push = in_pulse && (!w_full || w_pop);
    assign w_drop = in_pulse && w_full && !w_pop;

    rx_byte_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (out_data)
    );

    always_comb begin
        w_occ_next = r_occupancy;
        if (w_push && !w_pop) begin
            w_occ_next = r_occupancy + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_occ_next = r_occupancy - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap;
        case (r_state)
            IDLE: begin
                if (w_pop && (MIN_GAP_TICKS > 1)) begin
                    w_state_next = GAP;
                    w_gap_next   = GAP_W'(MIN_GAP_TICKS - 1);
                end
            end
            GAP: begin
                w_gap_next = r_gap - GAP_W'(1);
                if (r_gap == GAP_W'(1)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_gap_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gap       <= '0;
            r_occupancy <= '0;
            r_out_pulse <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_gap       <= w_gap_next;
            r_occupancy <= w_occ_next;
            r_out_pulse <= w_pop;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign occupancy = r_occupancy;
    assign out_pulse = r_out_pulse;
    assign overflow  = r_overflow;

`ifdef RX_BYTE_PACER_STATS_EN
    logic [15:0]      r_bytes_in;
    logic [15:0]      r_bytes_dropped;
    logic [CNT_W-1:0] r_peak;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_bytes_in      <= '0;
            r_bytes_dropped <= '0;
            r_peak          <= '0;
        end else begin
            if (w_push && (r_bytes_in != 16'hFFFF)) begin
                r_bytes_in <= r_bytes_in + 16'd1;
            end
            if (w_drop && (r_bytes_dropped != 16'hFFFF)) begin
                r_bytes_dropped <= r_bytes_dropped + 16'd1;
            end
            if (w_occ_next > r_peak) begin
                r_peak <= w_occ_next;
            end
        end
    end

    assign bytes_in_count      = r_bytes_in;
    assign bytes_dropped_count = r_bytes_dropped;
    assign peak_occupancy      = r_peak;
`endif

endmodule

// File: tb/tb_rx_byte_pacer.sv
// Self-checking bench for rx_byte_pacer (DEPTH=4, MIN_GAP_TICKS=3) against a queue-based reference model.
module tb_rx_byte_pacer;
    import rx_byte_pacer_pkg::*;

    localparam int DEPTH = RX_PACER_SIM_DEPTH;
    localparam int GAP   = RX_PACER_SIM_MIN_GAP_TICKS;
    localparam int OCC_W = rx_pacer_count_bits(DEPTH);

    logic             clk_in = 1'b0;
    logic             reset;
    logic [7:0]       in_data;
    logic             in_pulse;
    logic             consumer_busy;
    logic             clear_overflow;
    logic [7:0]       out_data;
    logic             out_pulse;
    logic [OCC_W-1:0] occupancy;
    logic             overflow;
`ifdef RX_BYTE_PACER_STATS_EN
    logic [15:0]      bytes_in_count;
    logic [15:0]      bytes_dropped_count;
    logic [OCC_W-1:0] peak_occupancy;
`endif

    rx_byte_pacer #(
        .DEPTH         (DEPTH),
        .MIN_GAP_TICKS (GAP),
        .DATA_WIDTH    (8)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .in_data        (in_data),
        .in_pulse       (in_pulse),
        .consumer_busy  (consumer_busy),
        .out_data       (out_data),
        .out_pulse      (out_pulse),
        .occupancy      (occupancy),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef RX_BYTE_PACER_STATS_EN
        ,
        .bytes_in_count      (bytes_in_count),
        .bytes_dropped_count (bytes_dropped_count),
        .peak_occupancy      (peak_occupancy)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Reference model: byte queue plus the edge index of the last issued pulse.
    byte unsigned m_q[$];
    logic [7:0]   m_out_data;
    logic         m_out_pulse;
    logic         m_overflow;
    int           m_edge;
    int           m_last_pop;
    int           n_cmp;
    int           n_err;

    task automatic model_reset();
        m_q.delete();
        m_out_data  = 8'h00;
        m_out_pulse = 1'b0;
        m_overflow  = 1'b0;
        m_last_pop  = -1000;
    endtask

    // One clock: apply the model rules to the inputs sampled at this edge, then settle.
    task automatic tick();
        bit pop;
        bit full;
        @(posedge clk_in);
        if (reset) begin
            model_reset();
        end else begin
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && !consumer_busy && ((m_edge - m_last_pop) >= GAP);
            m_out_pulse = pop;
            if (pop) begin
                m_out_data = m_q.pop_front();
                m_last_pop = m_edge;
            end
            if (in_pulse && (!full || pop)) m_q.push_back(in_data);
            if (in_pulse && full && !pop) m_overflow = 1'b1;
            else if (clear_overflow) m_overflow = 1'b0;
        end
        m_edge++;
        #1;
        if (out_pulse === 1'b1) $display("t=%0t out_pulse data=%02h occ=%0d", $time, out_data, occupancy);
    endtask

    task automatic idle_inputs();
        in_pulse       = 1'b0;
        in_data        = 8'h00;
        clear_overflow = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        consumer_busy = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({out_pulse, out_data, occupancy, overflow} !== '0 || dut.r_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got p=%0b d=%02h occ=%0d ovf=%0b st=%0d want all 0, IDLE",
                     out_pulse, out_data, occupancy, overflow, dut.r_state);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== '0) begin
                n_err++;
                $display("FAIL reset_release c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want all 0",
                         c, out_pulse, out_data, occupancy, overflow);
            end
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 6; c++) begin
            in_pulse = (c == 0);
            in_data  = (c == 0) ? 8'h62 : 8'h00;
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== {m_out_pulse, m_out_data, OCC_W'(m_q.size()), m_overflow}) begin
                n_err++;
                $display("FAIL single c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want p=%0b d=%02h occ=%0d ovf=%0b",
                         c, out_pulse, out_data, occupancy, overflow, m_out_pulse, m_out_data, m_q.size(), m_overflow);
            end
        end
    endtask

    task automatic test_burst();
        for (int c = 0; c < 14; c++) begin
            in_pulse = (c < 3);
            in_data  = (c < 3) ? 8'(c + 1) : 8'h00;
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== {m_out_pulse, m_out_data, OCC_W'(m_q.size()), m_overflow}) begin
                n_err++;
                $display("FAIL burst c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want p=%0b d=%02h occ=%0d ovf=%0b",
                         c, out_pulse, out_data, occupancy, overflow, m_out_pulse, m_out_data, m_q.size(), m_overflow);
            end
        end
    endtask

    task automatic test_busy_hold();
        for (int c = 0; c < 14; c++) begin
            consumer_busy = (c < 5);
            in_pulse      = (c < 2);
            in_data       = (c == 0) ? 8'hAA : 8'hBB;
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== {m_out_pulse, m_out_data, OCC_W'(m_q.size()), m_overflow}) begin
                n_err++;
                $display("FAIL busy_hold c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want p=%0b d=%02h occ=%0d ovf=%0b",
                         c, out_pulse, out_data, occupancy, overflow, m_out_pulse, m_out_data, m_q.size(), m_overflow);
            end
        end
        consumer_busy = 1'b0;
        idle_inputs();
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 22; c++) begin
            consumer_busy  = (c < 6);
            in_pulse       = (c < 5);
            in_data        = 8'h10 + 8'(c);
            clear_overflow = (c == 19);
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== {m_out_pulse, m_out_data, OCC_W'(m_q.size()), m_overflow}) begin
                n_err++;
                $display("FAIL overflow c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want p=%0b d=%02h occ=%0d ovf=%0b",
                         c, out_pulse, out_data, occupancy, overflow, m_out_pulse, m_out_data, m_q.size(), m_overflow);
            end
        end
        idle_inputs();
    endtask

    task automatic test_full_pop();
        for (int c = 0; c < 20; c++) begin
            consumer_busy  = (c < 4);
            in_pulse       = (c < 5);
            in_data        = 8'h20 + 8'(c);
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== {m_out_pulse, m_out_data, OCC_W'(m_q.size()), m_overflow}) begin
                n_err++;
                $display("FAIL full_pop c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want p=%0b d=%02h occ=%0d ovf=%0b",
                         c, out_pulse, out_data, occupancy, overflow, m_out_pulse, m_out_data, m_q.size(), m_overflow);
            end
        end
        idle_inputs();
    endtask

    task automatic test_set_wins();
        for (int c = 0; c < 20; c++) begin
            consumer_busy  = (c < 6);
            in_pulse       = (c < 5);
            in_data        = 8'h30 + 8'(c);
            clear_overflow = (c == 4) || (c == 5);
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== {m_out_pulse, m_out_data, OCC_W'(m_q.size()), m_overflow}) begin
                n_err++;
                $display("FAIL set_wins c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want p=%0b d=%02h occ=%0d ovf=%0b",
                         c, out_pulse, out_data, occupancy, overflow, m_out_pulse, m_out_data, m_q.size(), m_overflow);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        consumer_busy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_pulse = 1'b1;
            in_data  = 8'h40 + 8'(c);
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== {m_out_pulse, m_out_data, OCC_W'(m_q.size()), m_overflow}) begin
                n_err++;
                $display("FAIL async_pre c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want p=%0b d=%02h occ=%0d ovf=%0b",
                         c, out_pulse, out_data, occupancy, overflow, m_out_pulse, m_out_data, m_q.size(), m_overflow);
            end
        end
        idle_inputs();
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_pulse, out_data, occupancy, overflow} !== '0) begin
            n_err++;
            $display("FAIL async_immediate: got p=%0b d=%02h occ=%0d ovf=%0b want all 0",
                     out_pulse, out_data, occupancy, overflow);
        end
        model_reset();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== '0) begin
                n_err++;
                $display("FAIL async_post c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want all 0",
                         c, out_pulse, out_data, occupancy, overflow);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset          = (reset == 1'b0) && ($urandom_range(99) == 0);
            in_pulse       = ($urandom_range(1) == 1);
            in_data        = 8'($urandom);
            consumer_busy  = ($urandom_range(9) < 3);
            clear_overflow = ($urandom_range(19) == 0);
            tick();
            n_cmp++;
            if ({out_pulse, out_data, occupancy, overflow} !== {m_out_pulse, m_out_data, OCC_W'(m_q.size()), m_overflow}) begin
                n_err++;
                $display("FAIL random c%0d: got p=%0b d=%02h occ=%0d ovf=%0b want p=%0b d=%02h occ=%0d ovf=%0b",
                         c, out_pulse, out_data, occupancy, overflow, m_out_pulse, m_out_data, m_q.size(), m_overflow);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        m_edge = 0;
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_busy_hold();
        test_overflow();
        test_full_pop();
        test_set_wins();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_byte_pacer.md
Name: rx_byte_pacer

Overview:
Elastic byte buffer and pacing stage between the UART/SPI receive path (after ff_sync) and control_module. It absorbs received bytes into a small FIFO and re-issues them as single-cycle pulses. Pulses are spaced by a programmable minimum gap and are withheld while control_module reports busy, so command bytes are never dropped during RAM write bursts.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
MIN_GAP_TICKS, 4, minimum clk_in cycles between successive out_pulse assertions; >= 1 (1 = back-to-back)
DATA_WIDTH, 8, byte width

Ports:
clk_in  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-high reset
in_data  input  DATA_WIDTH  received byte; valid when in_pulse is high
in_pulse  input  1  single-cycle strobe from ff_sync sync_pulse
consumer_busy  input  1  control_module busy; 1 = no new byte may be issued
out_data  output  DATA_WIDTH  byte presented to control_module data_rx; held stable between pulses
out_pulse  output  1  single-cycle strobe to control_module data_ready_n (non-SPI polarity)
occupancy  output  $clog2(DEPTH)+1  current FIFO fill count, 0..DEPTH
overflow  output  1  sticky; set when a byte is dropped
clear_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release): pointers=0, occupancy=0, out_data=0, out_pulse=0, overflow=0, FSM=IDLE, gap counter=0.
- Push: in_pulse sampled high -> in_data written at that edge.
  - Full with no pop in the same cycle -> byte dropped, overflow<=1.
  - Full with a pop in the same cycle -> push accepted; occupancy unchanged.
- Pointers wrap modulo DEPTH. Occupancy is a separate counter: +1 push only, -1 pop only, unchanged for both or neither.
- FSM states: IDLE, GAP.
  - IDLE: if occupancy!=0 && !consumer_busy -> pop head into out_data, out_pulse<=1 for exactly one cycle, load gap counter with MIN_GAP_TICKS-1, go to GAP. If MIN_GAP_TICKS==1, stay in IDLE instead.
  - GAP: decrement each cycle. At 0 -> IDLE. consumer_busy is ignored while in GAP.
- consumer_busy is evaluated only in IDLE. It blocks pops indefinitely and never drops data.
- Latency:
  - Byte pushed at edge k into an empty FIFO, with FSM in IDLE and consumer not busy -> out_pulse high in the cycle after edge k+1.
  - Minimum pulse spacing is MIN_GAP_TICKS cycles (rising edge to rising edge).
- out_data changes only on the edge that asserts out_pulse.
- clear_overflow and a drop event in the same cycle -> overflow stays 1 (set wins).
- in_pulse held high for several cycles pushes one byte per cycle. This is a caller error, but behaviour is still as defined above.
- Reset mid-burst discards all buffered bytes. No pulse is issued during reset or on the release cycle.

Optional Feature:
RX_BYTE_PACER_STATS_EN
- Defined: adds outputs bytes_in_count[15:0] (accepted pushes), bytes_dropped_count[15:0], and peak_occupancy[$clog2(DEPTH):0].
  - All counters reset to 0 and saturate at max; they do not wrap.
  - peak_occupancy holds the highest occupancy seen since reset.
- Undefined: these ports and their logic are absent. The core behaviour is identical.

Decomposition:
- params_pkg: RX_PACER_DEPTH, RX_PACER_MIN_GAP_TICKS defaults. Add simulation variants so tb_* benches can use a short gap.
- calc_pkg: function rx_pacer_count_bits(depth) returning $clog2(depth)+1.
- Pacer FSM state enum (IDLE, GAP) lives in the package as a typedef so benches can probe it.
- One sub-module: rx_byte_fifo, a synchronous DEPTH x DATA_WIDTH storage array with wrapping pointers. rx_byte_pacer owns the occupancy, overflow and FSM logic.

Test Plan:
All scenarios use DEPTH=4 and MIN_GAP_TICKS=3.
- Single byte: in_pulse with in_data=8'h62 into empty FIFO, consumer idle -> out_pulse one cycle later, out_data=8'h62, occupancy returns to 0.
- Burst pacing: push 8'h01,8'h02,8'h03 on consecutive cycles -> three out_pulse strobes exactly 3 cycles apart, in order 01,02,03.
- Busy hold: consumer_busy=1, push 8'hAA,8'hBB -> no out_pulse, occupancy=2. Drop busy -> AA issued next cycle, BB 3 cycles later.
- Overflow: busy=1, push 5 bytes 8'h10..8'h14 -> occupancy=4, overflow=1, 8'h14 lost. Release busy -> 10,11,12,13 issued. clear_overflow -> overflow=0.
- Full with simultaneous pop: FIFO full with FSM in IDLE, busy drops in the same cycle as in_pulse -> push accepted, occupancy stays 4, overflow stays 0.
- Async reset mid-burst: assert reset between pulses with occupancy=3 -> out_pulse=0, occupancy=0, out_data=0 immediately. No pulse after release until a new push.
